// File: rtl/operand_fetch_bypass_stage.sv
// Operand fetch with same-cycle writeback bypass; operands registered, latency 1 cycle.
// Backpressure: in_ready = !out_valid || out_ready; a stalled output keeps snooping writebacks.
module operand_fetch_bypass_stage #(
  parameter int NUM_LANES   = 16,
  parameter int NUM_THREADS = 4,
  parameter int NUM_REGS    = 64,
  parameter int DATA_WIDTH  = 32,
  parameter int TAG_WIDTH   = 8,
  localparam int TW = $clog2(NUM_THREADS),
  localparam int RW = $clog2(NUM_REGS),
  localparam int VW = NUM_LANES * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TW-1:0]         in_thread,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic [RW-1:0]         in_src1_sel,
  input  logic                  in_src1_vec,
  input  logic [RW-1:0]         in_src2_sel,
  input  logic [1:0]            in_src2_kind,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [RW-1:0]         in_src3_sel,
  input  logic                  in_src3_vec,
  input  logic                  in_mask_en,
  input  logic [RW-1:0]         in_mask_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TW-1:0]         out_thread,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic [VW-1:0]         out_op1,
  output logic [VW-1:0]         out_op2,
  output logic [VW-1:0]         out_op3,
  output logic [NUM_LANES-1:0]  out_mask,
  output logic [VW-1:0]         out_store,
  input  logic                  wb_en,
  input  logic [TW-1:0]         wb_thread,
  input  logic                  wb_vector,
  input  logic [RW-1:0]         wb_reg,
  input  logic [VW-1:0]         wb_value,
  input  logic [NUM_LANES-1:0]  wb_mask,
  input  logic                  rollback_en,
  input  logic [TW-1:0]         rollback_thread
);

  localparam int DEPTH = NUM_THREADS * NUM_REGS;

  typedef struct packed {
    logic [RW-1:0] src1_sel;
    logic          src1_vec;
    logic [RW-1:0] src2_sel;
    logic [1:0]    src2_kind;
    logic [RW-1:0] src3_sel;
    logic          src3_vec;
    logic          mask_en;
    logic [RW-1:0] mask_sel;
  } meta_t;

  logic [DATA_WIDTH-1:0] sfile [DEPTH];
  logic [VW-1:0]         vfile [DEPTH];

  meta_t                 held;
  logic                  accept;
  logic                  wb_s;
  logic                  wb_v;
  logic [DATA_WIDTH-1:0] wb_lane0;
  logic [NUM_LANES-1:0]  wb_lane_en;

  function automatic logic [VW-1:0] bcast(input logic [DATA_WIDTH-1:0] d);
    bcast = {NUM_LANES{d}};
  endfunction

  function automatic logic [VW-1:0] merge(input logic [VW-1:0] old_v, input logic [VW-1:0] new_v,
                                          input logic [NUM_LANES-1:0] en);
    merge = old_v;
    for (int i = 0; i < NUM_LANES; i++)
      if (en[i]) merge[i*DATA_WIDTH +: DATA_WIDTH] = new_v[i*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  function automatic logic hit(input logic en, input logic [TW-1:0] ta, input logic [TW-1:0] tb,
                               input logic [RW-1:0] ra, input logic [RW-1:0] rb);
    hit = en && (ta == tb) && (ra == rb);
  endfunction

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_s     = wb_en && !wb_vector;
  assign wb_v     = wb_en && wb_vector;
  assign wb_lane0 = wb_value[DATA_WIDTH-1:0];

  // wb_mask is MSB-first: its top bit enables lane 0
  always_comb begin
    wb_lane_en = '0;
    for (int i = 0; i < NUM_LANES; i++) wb_lane_en[i] = wb_mask[NUM_LANES-1-i];
  end

  always_ff @(posedge clk) begin
    if (wb_v) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (wb_lane_en[i])
          vfile[{wb_thread, wb_reg}][i*DATA_WIDTH +: DATA_WIDTH] <= wb_value[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (wb_s) begin
      sfile[{wb_thread, wb_reg}] <= wb_lane0;
    end
  end

  logic [DATA_WIDTH-1:0] s1_rd, s2_rd, s3_rd;
  logic [NUM_LANES-1:0]  sm_rd;
  logic [VW-1:0]         v1_rd, v2_rd, v3_rd;
  logic [VW-1:0]         op1_n, op2_n, op3_n, store_n;
  logic [NUM_LANES-1:0]  mask_n;

  assign s1_rd = hit(wb_s, wb_thread, in_thread, wb_reg, in_src1_sel) ? wb_lane0 : sfile[{in_thread, in_src1_sel}];
  assign s2_rd = hit(wb_s, wb_thread, in_thread, wb_reg, in_src2_sel) ? wb_lane0 : sfile[{in_thread, in_src2_sel}];
  assign s3_rd = hit(wb_s, wb_thread, in_thread, wb_reg, in_src3_sel) ? wb_lane0 : sfile[{in_thread, in_src3_sel}];
  assign sm_rd = hit(wb_s, wb_thread, in_thread, wb_reg, in_mask_sel) ? wb_value[NUM_LANES-1:0]
                                                                       : sfile[{in_thread, in_mask_sel}][NUM_LANES-1:0];

  assign v1_rd = merge(vfile[{in_thread, in_src1_sel}], wb_value,
                       wb_lane_en & {NUM_LANES{hit(wb_v, wb_thread, in_thread, wb_reg, in_src1_sel)}});
  assign v2_rd = merge(vfile[{in_thread, in_src2_sel}], wb_value,
                       wb_lane_en & {NUM_LANES{hit(wb_v, wb_thread, in_thread, wb_reg, in_src2_sel)}});
  assign v3_rd = merge(vfile[{in_thread, in_src3_sel}], wb_value,
                       wb_lane_en & {NUM_LANES{hit(wb_v, wb_thread, in_thread, wb_reg, in_src3_sel)}});

  assign op1_n   = in_src1_vec ? v1_rd : bcast(s1_rd);
  assign op2_n   = in_src2_kind[1] ? bcast(in_imm) : (in_src2_kind[0] ? v2_rd : bcast(s2_rd));
  assign op3_n   = in_src3_vec ? v3_rd : bcast(s3_rd);
  assign store_n = in_src3_vec ? v3_rd : {{(VW-DATA_WIDTH){1'b0}}, s3_rd};
  assign mask_n  = in_mask_en ? sm_rd : {NUM_LANES{1'b1}};

  // Snoop terms for the held instruction; immediates (src2_kind[1]) never match
  logic h1_s, h1_v, h2_s, h2_v, h3_s, h3_v, hm;
  logic [VW-1:0] snp_op1, snp_op2, snp_op3, snp_store;

  assign h1_s = !held.src1_vec && hit(wb_s, wb_thread, out_thread, wb_reg, held.src1_sel);
  assign h1_v =  held.src1_vec && hit(wb_v, wb_thread, out_thread, wb_reg, held.src1_sel);
  assign h2_s = (held.src2_kind == 2'd0) && hit(wb_s, wb_thread, out_thread, wb_reg, held.src2_sel);
  assign h2_v = (held.src2_kind == 2'd1) && hit(wb_v, wb_thread, out_thread, wb_reg, held.src2_sel);
  assign h3_s = !held.src3_vec && hit(wb_s, wb_thread, out_thread, wb_reg, held.src3_sel);
  assign h3_v =  held.src3_vec && hit(wb_v, wb_thread, out_thread, wb_reg, held.src3_sel);
  assign hm   =  held.mask_en  && hit(wb_s, wb_thread, out_thread, wb_reg, held.mask_sel);

  assign snp_op1   = h1_s ? bcast(wb_lane0) : merge(out_op1, wb_value, wb_lane_en & {NUM_LANES{h1_v}});
  assign snp_op2   = h2_s ? bcast(wb_lane0) : merge(out_op2, wb_value, wb_lane_en & {NUM_LANES{h2_v}});
  assign snp_op3   = h3_s ? bcast(wb_lane0) : merge(out_op3, wb_value, wb_lane_en & {NUM_LANES{h3_v}});
  assign snp_store = held.src3_vec ? snp_op3 : (h3_s ? {{(VW-DATA_WIDTH){1'b0}}, wb_lane0} : out_store);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_thread <= '0;
      out_tag    <= '0;
      out_op1    <= '0;
      out_op2    <= '0;
      out_op3    <= '0;
      out_mask   <= '0;
      out_store  <= '0;
      held       <= '0;
    end else if (accept) begin
      out_valid  <= !(rollback_en && (rollback_thread == in_thread));
      out_thread <= in_thread;
      out_tag    <= in_tag;
      out_op1    <= op1_n;
      out_op2    <= op2_n;
      out_op3    <= op3_n;
      out_mask   <= mask_n;
      out_store  <= store_n;
      held       <= '{src1_sel: in_src1_sel, src1_vec: in_src1_vec, src2_sel: in_src2_sel,
                      src2_kind: in_src2_kind, src3_sel: in_src3_sel, src3_vec: in_src3_vec,
                      mask_en: in_mask_en, mask_sel: in_mask_sel};
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (rollback_en && (rollback_thread == out_thread)) out_valid <= 1'b0;
      out_op1   <= snp_op1;
      out_op2   <= snp_op2;
      out_op3   <= snp_op3;
      out_store <= snp_store;
      if (hm) out_mask <= wb_value[NUM_LANES-1:0];
    end
  end

endmodule

// File: tb/tb_operand_fetch_bypass_stage.sv
// Randomized bench for operand_fetch_bypass_stage: a register-file model in which a
// held instruction always reflects the live register contents, plus literal directed checks.
module tb_operand_fetch_bypass_stage;
  localparam int NL = 16, NT = 4, NR = 64, DW = 32, TGW = 8;
  localparam int TW = 2, RW = 6, VW = NL * DW;

  logic clk = 1'b0;
  logic reset_n;
  logic in_valid, in_ready;
  logic [TW-1:0] in_thread;
  logic [TGW-1:0] in_tag;
  logic [RW-1:0] in_src1_sel, in_src2_sel, in_src3_sel, in_mask_sel;
  logic in_src1_vec, in_src3_vec, in_mask_en;
  logic [1:0] in_src2_kind;
  logic [DW-1:0] in_imm;
  logic out_valid, out_ready;
  logic [TW-1:0] out_thread;
  logic [TGW-1:0] out_tag;
  logic [VW-1:0] out_op1, out_op2, out_op3, out_store;
  logic [NL-1:0] out_mask;
  logic wb_en, wb_vector, rollback_en;
  logic [TW-1:0] wb_thread, rollback_thread;
  logic [RW-1:0] wb_reg;
  logic [VW-1:0] wb_value;
  logic [NL-1:0] wb_mask;

  operand_fetch_bypass_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_thread(in_thread), .in_tag(in_tag), .in_src1_sel(in_src1_sel), .in_src1_vec(in_src1_vec),
    .in_src2_sel(in_src2_sel), .in_src2_kind(in_src2_kind), .in_imm(in_imm),
    .in_src3_sel(in_src3_sel), .in_src3_vec(in_src3_vec), .in_mask_en(in_mask_en),
    .in_mask_sel(in_mask_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_thread(out_thread), .out_tag(out_tag), .out_op1(out_op1), .out_op2(out_op2),
    .out_op3(out_op3), .out_mask(out_mask), .out_store(out_store), .wb_en(wb_en),
    .wb_thread(wb_thread), .wb_vector(wb_vector), .wb_reg(wb_reg), .wb_value(wb_value),
    .wb_mask(wb_mask), .rollback_en(rollback_en), .rollback_thread(rollback_thread)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int xfer_cnt = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference state: register files plus the instruction currently presented
  logic [DW-1:0] ms [NT][NR];
  logic [VW-1:0] mv [NT][NR];
  bit m_valid = 0;
  int m_thread, m_s1, m_s2, m_k2, m_s3, m_msel;
  bit m_v1, m_v3, m_men;
  logic [TGW-1:0] m_tag;
  logic [DW-1:0] m_imm;

  function automatic logic [VW-1:0] live(input int t, input bit vec, input int r);
    if (vec) return mv[t][r];
    return {NL{ms[t][r]}};
  endfunction

  task automatic model_ops(output logic [VW-1:0] o1, output logic [VW-1:0] o2, output logic [VW-1:0] o3,
                           output logic [VW-1:0] st, output logic [NL-1:0] mk);
    logic [DW-1:0] mreg;
    o1 = live(m_thread, m_v1, m_s1);
    o2 = (m_k2 >= 2) ? {NL{m_imm}} : live(m_thread, m_k2 == 1, m_s2);
    o3 = live(m_thread, m_v3, m_s3);
    st = m_v3 ? o3 : {{(VW-DW){1'b0}}, ms[m_thread][m_s3]};
    mreg = ms[m_thread][m_msel];
    mk = m_men ? mreg[NL-1:0] : {NL{1'b1}};
  endtask

  // Writes land first, so reads in the same cycle see the new data (bypass)
  always @(posedge clk) begin
    bit acc;
    if (reset_n) begin
      acc = in_valid && (!m_valid || out_ready);
      if (wb_en) begin
        if (wb_vector) begin
          for (int i = 0; i < NL; i++)
            if (wb_mask[NL-1-i]) mv[int'(wb_thread)][int'(wb_reg)][i*DW +: DW] = wb_value[i*DW +: DW];
        end else begin
          ms[int'(wb_thread)][int'(wb_reg)] = wb_value[DW-1:0];
        end
      end
      if (acc) begin
        m_valid = !(rollback_en && rollback_thread == in_thread);
        m_thread = int'(in_thread); m_tag = in_tag;
        m_s1 = int'(in_src1_sel); m_v1 = in_src1_vec;
        m_s2 = int'(in_src2_sel); m_k2 = int'(in_src2_kind); m_imm = in_imm;
        m_s3 = int'(in_src3_sel); m_v3 = in_src3_vec;
        m_men = in_mask_en; m_msel = int'(in_mask_sel);
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end else if (m_valid && rollback_en && int'(rollback_thread) == m_thread) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge reset_n) m_valid = 0;

  always @(negedge clk) begin
    logic [VW-1:0] e1, e2, e3, es;
    logic [NL-1:0] em;
    if (out_valid && out_ready) xfer_cnt++;
    chk("in_ready", VW'(in_ready), VW'(!m_valid || out_ready));
    chk("out_valid", VW'(out_valid), VW'(m_valid));
    if (m_valid) begin
      model_ops(e1, e2, e3, es, em);
      chk("out_thread", VW'(out_thread), VW'(m_thread));
      chk("out_tag", VW'(out_tag), VW'(m_tag));
      chk("out_op1", out_op1, e1);
      chk("out_op2", out_op2, e2);
      chk("out_op3", out_op3, e3);
      chk("out_store", out_store, es);
      chk("out_mask", VW'(out_mask), VW'(em));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 0; wb_en = 0; rollback_en = 0;
  endtask

  function automatic logic [VW-1:0] rnd_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NL; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  task automatic set_wb(input int t, input int r, input bit vec, input logic [VW-1:0] v, input logic [NL-1:0] m);
    wb_en = 1; wb_thread = TW'(t); wb_reg = RW'(r); wb_vector = vec; wb_value = v; wb_mask = m;
  endtask

  task automatic set_fetch(input int t, input int tag, input int s1, input bit v1, input int s2, input int k2,
                           input logic [DW-1:0] imm, input int s3, input bit v3, input bit men, input int msel);
    in_valid = 1; in_thread = TW'(t); in_tag = TGW'(tag);
    in_src1_sel = RW'(s1); in_src1_vec = v1; in_src2_sel = RW'(s2); in_src2_kind = 2'(k2); in_imm = imm;
    in_src3_sel = RW'(s3); in_src3_vec = v3; in_mask_en = men; in_mask_sel = RW'(msel);
  endtask

  initial begin
    logic [VW-1:0] exp_v;
    int c0;
    reset_n = 0; out_ready = 1; rollback_thread = '0; wb_thread = '0; wb_vector = 0; wb_reg = '0;
    wb_value = '0; wb_mask = '0; idle();
    set_fetch(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
    #3;
    chk("reset_valid", VW'(out_valid), '0);
    chk("reset_tag", VW'(out_tag), '0);
    chk("reset_op1", out_op1, '0);
    chk("reset_store", out_store, '0);
    chk("reset_mask", VW'(out_mask), '0);
    #19 reset_n = 1;
    tick();

    // Give every register a defined value
    for (int t = 0; t < NT; t++)
      for (int r = 0; r < NR; r++) begin
        set_wb(t, r, 0, rnd_vec(), '0); tick();
        set_wb(t, r, 1, rnd_vec(), {NL{1'b1}}); tick();
      end
    idle();

    // Scalar fetch with immediate
    set_wb(1, 5, 0, VW'(32'h1234), '0); tick(); idle();
    set_fetch(1, 1, 5, 0, 0, 2, 32'h7, 0, 0, 0, 0); tick(); idle();
    chk("d1_valid", VW'(out_valid), VW'(1));
    chk("d1_op1", out_op1, {NL{32'h1234}});
    chk("d1_op2", out_op2, {NL{32'h7}});
    chk("d1_mask", VW'(out_mask), VW'(16'hFFFF));

    // Per-lane vector bypass of a masked write
    for (int i = 0; i < NL; i++) exp_v[i*DW +: DW] = i;
    set_wb(2, 3, 1, exp_v, 16'hFFFF); tick();
    set_wb(2, 3, 1, {NL{32'hFFFF}}, 16'h8000);
    set_fetch(2, 2, 3, 1, 0, 2, 0, 0, 0, 0, 0); tick(); idle();
    exp_v[DW-1:0] = 32'hFFFF;
    chk("d2_op1", out_op1, exp_v);

    // Snoop into a stalled output
    set_wb(3, 9, 0, VW'(32'h11), '0); tick(); idle();
    out_ready = 0;
    set_fetch(3, 8'h30, 0, 0, 9, 0, 0, 0, 0, 0, 0); tick();
    set_wb(3, 9, 0, VW'(32'hAB), '0); in_tag = 8'h31; tick(); wb_en = 0;
    chk("d3_op2", out_op2, {NL{32'hAB}});
    chk("d3_tag", VW'(out_tag), VW'(8'h30));
    chk("d3_in_ready", VW'(in_ready), '0);
    tick();
    chk("d3_in_ready2", VW'(in_ready), '0);
    c0 = xfer_cnt;
    out_ready = 1; in_valid = 0; tick(); tick();
    chk("d3_one_xfer", VW'(xfer_cnt - c0), VW'(1));
    chk("d3_drained", VW'(out_valid), '0);

    // Rollback in the accept cycle
    set_fetch(0, 8'h20, 0, 0, 0, 2, 0, 0, 0, 0, 0); rollback_en = 1; rollback_thread = 2'd0; tick(); idle();
    chk("d4_squash", VW'(out_valid), '0);
    set_fetch(0, 8'h21, 0, 0, 0, 2, 0, 0, 0, 0, 0); rollback_en = 1; rollback_thread = 2'd1; tick(); idle();
    chk("d4_keep", VW'(out_valid), VW'(1));

    // Scalar store value and mask register
    set_wb(0, 4, 0, VW'(32'h55), '0); tick();
    set_wb(0, 6, 0, VW'(32'h00F0), '0); tick(); idle();
    set_fetch(0, 8'h22, 0, 0, 0, 2, 0, 4, 0, 1, 6); tick(); idle();
    chk("d5_store", out_store, VW'(32'h55));
    chk("d5_mask", VW'(out_mask), VW'(16'h00F0));

    // Back-to-back stream
    for (int k = 0; k < 8; k++) begin
      set_fetch(k % NT, 8'h40 + k, k, 0, k, 0, 0, k, 0, 0, 0); tick();
      chk("d6_valid", VW'(out_valid), VW'(1));
      chk("d6_tag", VW'(out_tag), VW'(8'h40 + k));
    end
    idle(); tick();

    // Reset in the middle of a stream
    set_fetch(1, 8'h50, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_fetch(1, 8'h51, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick(); idle();
    #2 reset_n = 0;
    #1;
    chk("d7_rst_valid", VW'(out_valid), '0);
    chk("d7_rst_tag", VW'(out_tag), '0);
    chk("d7_rst_op1", out_op1, '0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    tick();
    set_fetch(1, 8'h52, 5, 0, 0, 2, 0, 0, 0, 0, 0); tick(); idle();
    chk("d7_kept_r5", out_op1, {NL{32'h1234}});

    // Randomized traffic with small register range to provoke hits
    for (int n = 0; n < 2000; n++) begin
      set_fetch($urandom_range(0, NT-1), n, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                $urandom_range(0, 7), $urandom_range(0, 3), $urandom, $urandom_range(0, 7),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      in_valid = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      set_wb($urandom_range(0, NT-1), $urandom_range(0, 7), 1'($urandom_range(0, 1)), rnd_vec(),
             NL'($urandom));
      wb_en = 1'($urandom_range(0, 1));
      rollback_en = ($urandom_range(0, 9) == 0);
      rollback_thread = TW'($urandom_range(0, NT-1));
      tick();
    end
    idle(); out_ready = 1; tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
